// File: rtl/sys_array_buf.sv
// -----------------------------------------------------------------------------
// sys_array_buf
//   Small register-file array shared between the CPU syscall path and a user
//   confirm/edit path. The CPU side walks the array sequentially through
//   `index`. INPUT_INT syscalls read an entry into sys_inf_in, and OUTPUT_INT
//   syscalls write sys_inf_out[15:0] into an entry. The user side writes
//   cur_num into array[cur_index] on each rising edge of confirm_efct.
//
// Ports
//   clk           system clock, rising-edge active
//   rst           synchronous, active-low reset
//   sysc_mp       syscall request level (rising edge = request)
//   sys_op        syscall operation code
//   sys_inf_out   CPU output data (bits [15:0] used)
//   confirm_efct  debounced user confirm level (rising edge = write)
//   cur_index     user-selected entry
//   cur_num       user value written on confirm
//   sys_inf_in    data returned to the CPU for input syscalls
//   sys_ack       one-cycle completion pulse per serviced syscall
//   index         sequential CPU-side traversal pointer
//   rd_data       array[cur_index], combinational
//   wrap          one-cycle pulse when index wraps to 0
// -----------------------------------------------------------------------------
`ifndef SYS_OP_LENGTH
`define SYS_OP_LENGTH 4
`endif
`ifndef SYSCALL_INPUT_INT
`define SYSCALL_INPUT_INT 4'd5
`endif
`ifndef SYSCALL_OUTPUT_INT
`define SYSCALL_OUTPUT_INT 4'd1
`endif

module sys_array_buf #(
    parameter int ARRAY_SIZE = 16,
    parameter int NUM_SIZE   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sysc_mp,
    input  logic [`SYS_OP_LENGTH-1:0] sys_op,
    input  logic [31:0]               sys_inf_out,
    input  logic                      confirm_efct,
    input  logic [3:0]                cur_index,
    input  logic [NUM_SIZE-1:0]       cur_num,
    output logic [31:0]               sys_inf_in,
    output logic                      sys_ack,
    output logic [3:0]                index,
    output logic [NUM_SIZE-1:0]       rd_data,
    output logic                      wrap
);

    localparam int         IDX_W    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [3:0] LAST_IDX = 4'(ARRAY_SIZE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [`SYS_OP_LENGTH-1:0] op_q, op_d;
    logic [3:0]                index_q, index_d;
    logic [31:0]               inf_q, inf_d;
    logic                      wrap_q, wrap_d;
    logic                      sys_pend_q, sys_pend_d;
    logic                      conf_req_q, conf_req_d;
    logic                      conf_def_q, conf_def_d;
    logic [3:0]                conf_idx_q, conf_idx_d;
    logic [NUM_SIZE-1:0]       conf_num_q, conf_num_d;
    logic [NUM_SIZE-1:0]       arr_q [ARRAY_SIZE];
    logic [NUM_SIZE-1:0]       arr_d [ARRAY_SIZE];

    // Edge-detect history; live_q masks the first cycle after reset so a
    // level already high at release is not taken as an edge.
    logic sysc_prev_q, conf_prev_q, live_q;
    logic sysc_edge, conf_edge;
    logic exec_wr;
    logic [3:0] next_idx;
    logic unused_hi;

    assign sysc_edge = live_q & sysc_mp & ~sysc_prev_q;
    assign conf_edge = live_q & confirm_efct & ~conf_prev_q;
    assign exec_wr   = (state_q == S_EXEC) && (op_q == `SYSCALL_OUTPUT_INT);
    assign next_idx  = (index_q == LAST_IDX) ? 4'd0 : index_q + 4'd1;
    assign unused_hi = ^sys_inf_out[31:16];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        index_d    = index_q;
        inf_d      = inf_q;
        wrap_d     = 1'b0;
        sys_pend_d = sys_pend_q;
        arr_d      = arr_q;

        case (state_q)
            S_IDLE: begin
                if (sysc_edge || sys_pend_q) begin
                    state_d    = S_EXEC;
                    op_d       = sys_op;
                    sys_pend_d = 1'b0;
                end
            end
            S_EXEC: begin
                state_d = S_ACK;
                if (sysc_edge) sys_pend_d = 1'b1;
                if (op_q == `SYSCALL_INPUT_INT) begin
                    inf_d   = 32'(arr_q[index_q[IDX_W-1:0]]);
                    index_d = next_idx;
                    wrap_d  = (index_q == LAST_IDX);
                end else if (op_q == `SYSCALL_OUTPUT_INT) begin
                    arr_d[index_q[IDX_W-1:0]] = NUM_SIZE'(sys_inf_out[15:0]);
                    index_d = next_idx;
                    wrap_d  = (index_q == LAST_IDX);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                if (sysc_edge) sys_pend_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Confirm path: edge captures index/value, the write lands one cycle
        // later, or two if that cycle is an EXEC output write. Applied after
        // the EXEC write so a deferred confirm to the same entry wins.
        conf_req_d = conf_edge;
        conf_idx_d = conf_edge ? cur_index : conf_idx_q;
        conf_num_d = conf_edge ? cur_num   : conf_num_q;
        conf_def_d = conf_req_q & exec_wr;
        if ((conf_req_q && !exec_wr) || conf_def_q)
            arr_d[conf_idx_q[IDX_W-1:0]] = conf_num_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            index_q     <= '0;
            inf_q       <= '0;
            wrap_q      <= 1'b0;
            sys_pend_q  <= 1'b0;
            conf_req_q  <= 1'b0;
            conf_def_q  <= 1'b0;
            conf_idx_q  <= '0;
            conf_num_q  <= '0;
            sysc_prev_q <= 1'b0;
            conf_prev_q <= 1'b0;
            live_q      <= 1'b0;
            for (int unsigned i = 0; i < ARRAY_SIZE; i++)
                arr_q[i] <= NUM_SIZE'(ARRAY_SIZE - i);
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            index_q     <= index_d;
            inf_q       <= inf_d;
            wrap_q      <= wrap_d;
            sys_pend_q  <= sys_pend_d;
            conf_req_q  <= conf_req_d;
            conf_def_q  <= conf_def_d;
            conf_idx_q  <= conf_idx_d;
            conf_num_q  <= conf_num_d;
            sysc_prev_q <= sysc_mp;
            conf_prev_q <= confirm_efct;
            live_q      <= 1'b1;
            arr_q       <= arr_d;
        end
    end

    assign sys_inf_in = inf_q;
    assign sys_ack    = (state_q == S_ACK);
    assign index      = index_q;
    assign wrap       = wrap_q;
    assign rd_data    = arr_q[cur_index[IDX_W-1:0]];

endmodule

// File: tb/tb_sys_array_buf.sv
`ifndef SYS_OP_LENGTH
`define SYS_OP_LENGTH 4
`endif
`ifndef SYSCALL_INPUT_INT
`define SYSCALL_INPUT_INT 4'd5
`endif
`ifndef SYSCALL_OUTPUT_INT
`define SYSCALL_OUTPUT_INT 4'd1
`endif

module tb_sys_array_buf;

    localparam logic [`SYS_OP_LENGTH-1:0] OP_IN    = `SYSCALL_INPUT_INT;
    localparam logic [`SYS_OP_LENGTH-1:0] OP_OUT   = `SYSCALL_OUTPUT_INT;
    localparam logic [`SYS_OP_LENGTH-1:0] OP_OTHER = 4'd10;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      sysc_mp;
    logic [`SYS_OP_LENGTH-1:0] sys_op;
    logic [31:0]               sys_inf_out;
    logic                      confirm_efct;
    logic [3:0]                cur_index;
    logic [15:0]               cur_num;
    logic [31:0]               sys_inf_in;
    logic                      sys_ack;
    logic [3:0]                index;
    logic [15:0]               rd_data;
    logic                      wrap;

    sys_array_buf #(.ARRAY_SIZE(16), .NUM_SIZE(16)) dut (
        .clk(clk), .rst(rst), .sysc_mp(sysc_mp), .sys_op(sys_op),
        .sys_inf_out(sys_inf_out), .confirm_efct(confirm_efct),
        .cur_index(cur_index), .cur_num(cur_num), .sys_inf_in(sys_inf_in),
        .sys_ack(sys_ack), .index(index), .rd_data(rd_data), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int wrap_seen = 0;

    // Transaction-level reference model
    logic [15:0] m_arr [16];
    int unsigned m_idx;
    logic [31:0] m_inf;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_arr[i] = 16'(16 - i);
        m_idx = 0;
        m_inf = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scan(input string tag);
        for (int i = 0; i < 16; i++) begin
            cur_index = 4'(i);
            #1;
            chk(tag, 32'(rd_data), 32'(m_arr[i]));
        end
    endtask

    task automatic model_exec(input logic [`SYS_OP_LENGTH-1:0] op, input logic [31:0] data,
                              output logic exp_wrap);
        exp_wrap = 1'b0;
        if (op == OP_IN) begin
            m_inf = {16'h0000, m_arr[m_idx]};
            m_idx = (m_idx + 1) % 16;
            exp_wrap = (m_idx == 0);
        end else if (op == OP_OUT) begin
            m_arr[m_idx] = data[15:0];
            m_idx = (m_idx + 1) % 16;
            exp_wrap = (m_idx == 0);
        end
    endtask

    // One syscall from idle, optionally with a confirm edge in the same cycle.
    task automatic do_sys(input logic [`SYS_OP_LENGTH-1:0] op, input logic [31:0] data,
                          input logic conf, input logic [3:0] ci, input logic [15:0] cn);
        logic exp_wrap;
        logic [15:0] ack_rd;
        sys_op = op;
        sys_inf_out = data;
        if (conf) begin
            cur_index = ci;
            cur_num = cn;
            confirm_efct = 1'b1;
        end
        sysc_mp = 1'b1;
        tick();
        chk("ack_in_exec", 32'(sys_ack), 32'd0);
        sysc_mp = 1'b0;
        confirm_efct = 1'b0;
        model_exec(op, data, exp_wrap);
        // A confirm colliding with an output write lands one cycle after it.
        if (conf && op != OP_OUT) m_arr[ci] = cn;
        ack_rd = m_arr[cur_index];
        if (conf && op == OP_OUT) m_arr[ci] = cn;
        tick();
        chk("ack_in_ack", 32'(sys_ack), 32'd1);
        chk("inf_in", sys_inf_in, m_inf);
        chk("index", 32'(index), m_idx);
        chk("wrap", 32'(wrap), 32'(exp_wrap));
        chk("rd_in_ack", 32'(rd_data), 32'(ack_rd));
        if (wrap) wrap_seen++;
        tick();
        chk("ack_after", 32'(sys_ack), 32'd0);
        chk("wrap_after", 32'(wrap), 32'd0);
        chk("rd_after", 32'(rd_data), 32'(m_arr[cur_index]));
    endtask

    task automatic pattern(input logic [15:0] pat, output logic [15:0] acks);
        for (int i = 0; i < 16; i++) begin
            sysc_mp = pat[i];
            tick();
            acks[i] = sys_ack;
        end
        sysc_mp = 1'b0;
    endtask

    initial begin
        logic [15:0] acks;
        logic        dummy_wrap;
        int          ack_cnt;
        logic [15:0] v;

        // Reset with both request levels already high
        rst = 1'b0; sysc_mp = 1'b1; confirm_efct = 1'b1; sys_op = OP_IN;
        cur_index = 4'd0; cur_num = 16'hBEEF; sys_inf_out = '0;
        tick(); tick();
        model_reset();
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_inf", sys_inf_in, 32'd0);
        chk("rst_ack", 32'(sys_ack), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        rst = 1'b1;
        ack_cnt = 0;
        repeat (4) begin tick(); ack_cnt += int'(sys_ack); end
        chk("held_at_release_ack", ack_cnt, 32'd0);
        chk("held_at_release_idx", 32'(index), 32'd0);
        chk("held_at_release_arr", 32'(rd_data), 32'h10);
        sysc_mp = 1'b0; confirm_efct = 1'b0;
        tick();
        scan("reset_array");

        // First input syscall after reset
        do_sys(OP_IN, 32'h0, 1'b0, 4'd0, 16'h0);
        chk("first_input_val", sys_inf_in, 32'h0000_0010);
        chk("first_input_idx", 32'(index), 32'd1);

        // Held syscall level yields a single request
        sys_op = OP_IN;
        sysc_mp = 1'b1;
        ack_cnt = 0;
        repeat (10) begin tick(); ack_cnt += int'(sys_ack); end
        sysc_mp = 1'b0;
        repeat (3) begin tick(); ack_cnt += int'(sys_ack); end
        model_exec(OP_IN, 32'h0, dummy_wrap);
        chk("held_sysc_acks", ack_cnt, 32'd1);
        chk("held_sysc_idx", 32'(index), m_idx);
        chk("held_sysc_inf", sys_inf_in, m_inf);

        // Standalone confirm, held level, value captured at the edge
        v = 16'($urandom);
        cur_index = 4'd7; cur_num = v; confirm_efct = 1'b1;
        tick(); tick();
        m_arr[7] = v;
        chk("confirm_write", 32'(rd_data), 32'(v));
        cur_num = ~v;
        tick(); tick();
        chk("confirm_single", 32'(rd_data), 32'(v));
        confirm_efct = 1'b0;
        tick();

        // Sixteen output writes from index 0
        rst = 1'b0; tick(); rst = 1'b1; model_reset(); tick();
        wrap_seen = 0;
        for (int i = 0; i < 16; i++) do_sys(OP_OUT, 32'(i) | 32'hABCD_0000, 1'b0, 4'd0, 16'h0);
        chk("wrap_count", wrap_seen, 32'd1);
        chk("idx_after_16", 32'(index), 32'd0);
        scan("array_0_to_15");

        // Confirm deferred by a colliding output write to the same entry
        repeat (3) do_sys(OP_IN, 32'h0, 1'b0, 4'd0, 16'h0);
        chk("idx_before_collide", 32'(index), 32'd3);
        do_sys(OP_OUT, 32'h0000_0055, 1'b1, 4'd3, 16'h00AA);
        chk("collide_final", 32'(rd_data), 32'h00AA);

        // Syscall edge during ACK becomes pending
        sys_op = OP_IN;
        pattern(16'b101, acks);
        model_exec(OP_IN, 32'h0, dummy_wrap);
        model_exec(OP_IN, 32'h0, dummy_wrap);
        chk("pending_acks", 32'(acks), 32'b1_0010);
        chk("pending_idx", 32'(index), m_idx);
        chk("pending_inf", sys_inf_in, m_inf);
        // Four edges: the one arriving while pending is already set is dropped
        pattern(16'b101_0101, acks);
        repeat (3) model_exec(OP_IN, 32'h0, dummy_wrap);
        chk("drop_acks", 32'(acks), 32'b1001_0010);
        chk("drop_idx", 32'(index), m_idx);
        chk("drop_inf", sys_inf_in, m_inf);

        // Reset during EXEC of an output write
        sys_op = OP_OUT; sys_inf_out = 32'h0000_1234;
        sysc_mp = 1'b1;
        tick();
        rst = 1'b0; sysc_mp = 1'b0;
        tick();
        chk("abort_ack_rst", 32'(sys_ack), 32'd0);
        rst = 1'b1;
        model_reset();
        tick();
        chk("abort_ack", 32'(sys_ack), 32'd0);
        tick();
        chk("abort_ack2", 32'(sys_ack), 32'd0);
        chk("abort_idx", 32'(index), 32'd0);
        scan("abort_array");

        // Randomized syscalls with occasional colliding confirms
        for (int n = 0; n < 48; n++) begin
            int unsigned r;
            logic [`SYS_OP_LENGTH-1:0] op;
            logic conf;
            logic [3:0] ci;
            r = $urandom_range(0, 3);
            op = (r == 0) ? OP_IN : (r == 2) ? OP_OTHER : OP_OUT;
            conf = ($urandom_range(0, 2) == 0);
            ci = ($urandom_range(0, 1) == 0) ? 4'(m_idx) : 4'($urandom);
            do_sys(op, $urandom, conf, ci, 16'($urandom));
        end
        scan("random_array");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
